gray_ptr_sync_decoder: RTL and testbench

Receiving end of the gray-coded pointer interface driven by gray_counter. It samples a gray pointer from the producer side through a multi-flop synchronizer and decodes it to binary. It then compares the result against the local binary pointer to produce occupancy, empty and full, plus sticky integrity errors. It sits on the read side of the FIFO/line-buffer path feeding the CNN datapath.

---
 rtl/gray_ptr_sync_decoder_pkg.sv | 35 +++
 rtl/gray_ptr_sync_decoder_sync.sv | 32 +++
 rtl/gray_ptr_sync_decoder.sv | 73 +++++++
 tb/tb_gray_ptr_sync_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_ptr_sync_decoder_pkg.sv
// Shared gray-pointer helpers: gray/binary conversion, popcount and buffer depth.
// Functions take zero-extended 32-bit operands so any pointer width up to 32 works.
package gray_ptr_sync_decoder_pkg;

    localparam int MAX_BITS = 32;

    function automatic logic [MAX_BITS-1:0] bin2gray(input logic [MAX_BITS-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits XOR to zero, so the decode is width-agnostic.
    function automatic logic [MAX_BITS-1:0] gray2bin(input logic [MAX_BITS-1:0] g);
        logic [MAX_BITS-1:0] b;
        b[MAX_BITS-1] = g[MAX_BITS-1];
        for (int i = MAX_BITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int popcount(input logic [MAX_BITS-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_BITS; i++) begin
            cnt += int'(v[i]);
        end
        return cnt;
    endfunction

    // Pointer carries one wrap bit above the address bits.
    function automatic int depth_of(input int num_bits);
        return 1 << (num_bits - 1);
    endfunction

endpackage

// File: rtl/gray_ptr_sync_decoder_sync.sv
// Parameterized N-stage flop synchronizer with synchronous active-high reset.
// Plain flop chain with no logic between stages; reusable for any crossing pointer.
module gray_ptr_sync_decoder_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // NOTE: every stage is reset explicitly; a flop array left unreset would
    // present X to the decoder until the chain had flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync_decoder.sv
// Read-side receiver of a gray-coded write pointer: synchronize, decode to binary,
// and derive occupancy, empty/full and sticky integrity errors against rd_bin.
module gray_ptr_sync_decoder
    import gray_ptr_sync_decoder_pkg::*;
#(
    parameter int NUM_BITS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] gray_in,
    input  logic [NUM_BITS-1:0] rd_bin,
    input  logic                clr_err,
    output logic [NUM_BITS-1:0] wr_bin,
    output logic                wr_adv,
    output logic [NUM_BITS-1:0] level,
    output logic                empty,
    output logic                full,
    output logic                step_err,
    output logic                ovf_err
);

    localparam logic [NUM_BITS-1:0] DEPTH = NUM_BITS'(depth_of(NUM_BITS));

    logic [NUM_BITS-1:0] sync;
    logic [NUM_BITS-1:0] prev;
    logic [NUM_BITS-1:0] sync_bin;
    logic [NUM_BITS-1:0] diff;
    logic                bad_step;
    logic                overflow;

    gray_ptr_sync_decoder_sync #(
        .WIDTH (NUM_BITS),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (gray_in),
        .q  (sync)
    );

    assign sync_bin = NUM_BITS'(gray2bin(32'(sync)));
    // Modular subtraction: wrap of either pointer falls out naturally.
    assign diff     = wr_bin - rd_bin;
    assign bad_step = popcount(32'(sync ^ prev)) > 1;
    assign overflow = diff > DEPTH;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '0;
            wr_bin   <= '0;
            wr_adv   <= 1'b0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            step_err <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            prev   <= sync;
            wr_bin <= sync_bin;
            wr_adv <= sync_bin != wr_bin;
            level  <= diff;
            empty  <= diff == '0;
            full   <= diff == DEPTH;
            // A new violation outranks a simultaneous clear.
            step_err <= bad_step | (step_err & ~clr_err);
            ovf_err  <= overflow | (ovf_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_gray_ptr_sync_decoder.sv
// Directed bench for gray_ptr_sync_decoder: expected outputs are queued as each
// stimulus step is driven and popped for comparison once the DUT has settled.
module tb_gray_ptr_sync_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] gray_in;
    logic [3:0] rd_bin;
    logic       clr_err;
    logic [3:0] wr_bin;
    logic       wr_adv;
    logic [3:0] level;
    logic       empty;
    logic       full;
    logic       step_err;
    logic       ovf_err;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [3:0] wr_bin;
        logic       wr_adv;
        logic [3:0] level;
        logic       empty;
        logic       full;
        logic       step_err;
        logic       ovf_err;
    } exp_t;

    exp_t sb[$];

    gray_ptr_sync_decoder #(
        .NUM_BITS   (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .gray_in (gray_in),
        .rd_bin  (rd_bin),
        .clr_err (clr_err),
        .wr_bin  (wr_bin),
        .wr_adv  (wr_adv),
        .level   (level),
        .empty   (empty),
        .full    (full),
        .step_err(step_err),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // empty/full follow from the expected level: empty at 0, full at DEPTH=8.
    task automatic push(input string tag, input logic [3:0] wb, input logic adv,
                        input logic [3:0] lv, input logic se, input logic oe);
        exp_t e;
        e.tag      = tag;
        e.wr_bin   = wb;
        e.wr_adv   = adv;
        e.level    = lv;
        e.empty    = (lv == 4'd0);
        e.full     = (lv == 4'd8);
        e.step_err = se;
        e.ovf_err  = oe;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field, input logic [3:0] got,
                       input logic [3:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %h expected %h", tag, field, got, want);
        end
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "wr_bin",   wr_bin,          e.wr_bin);
        cmp(e.tag, "wr_adv",   {3'b0, wr_adv},  {3'b0, e.wr_adv});
        cmp(e.tag, "level",    level,           e.level);
        cmp(e.tag, "empty",    {3'b0, empty},   {3'b0, e.empty});
        cmp(e.tag, "full",     {3'b0, full},    {3'b0, e.full});
        cmp(e.tag, "step_err", {3'b0, step_err}, {3'b0, e.step_err});
        cmp(e.tag, "ovf_err",  {3'b0, ovf_err}, {3'b0, e.ovf_err});
    endtask

    // Apply one legal gray step and wait until both wr_bin and level have settled.
    task automatic settle(input string tag, input logic [3:0] g, input logic [3:0] wb,
                          input logic [3:0] lv, input logic se, input logic oe);
        gray_in = g;
        push(tag, wb, 1'b0, lv, se, oe);
        repeat (4) tick();
        check();
    endtask

    initial begin
        rst = 1'b1; gray_in = 4'hF; rd_bin = 4'd0; clr_err = 1'b0;
        #1;
        repeat (3) tick();
        push("reset", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0); check();

        rst = 1'b0; gray_in = 4'h0;
        push("post_reset", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) tick(); check();

        // Latency: wr_bin 3 edges, level 4 edges after gray_in changes.
        gray_in = 4'h1;
        push("lat_e2", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) tick(); check();
        push("lat_e3", 4'd1, 1'b1, 4'd0, 1'b0, 1'b0);
        tick(); check();
        push("lat_e4", 4'd1, 1'b0, 4'd1, 1'b0, 1'b0);
        tick(); check();

        // Back-to-back steps keep wr_adv high.
        gray_in = 4'h3; tick();
        gray_in = 4'h2; tick();
        gray_in = 4'h6;
        push("stream_b2", 4'd2, 1'b1, 4'd1, 1'b0, 1'b0);
        tick(); check();
        push("stream_b3", 4'd3, 1'b1, 4'd2, 1'b0, 1'b0);
        tick(); check();
        push("stream_b4", 4'd4, 1'b1, 4'd3, 1'b0, 1'b0);
        tick(); check();
        push("stream_end", 4'd4, 1'b0, 4'd4, 1'b0, 1'b0);
        tick(); check();

        // Full and overflow.
        settle("b5", 4'h7, 4'd5, 4'd5, 1'b0, 1'b0);
        settle("b6", 4'h5, 4'd6, 4'd6, 1'b0, 1'b0);
        settle("b7", 4'h4, 4'd7, 4'd7, 1'b0, 1'b0);
        settle("b8_full", 4'hC, 4'd8, 4'd8, 1'b0, 1'b0);
        settle("b9_ovf", 4'hD, 4'd9, 4'd9, 1'b0, 1'b1);
        push("ovf_hold", 4'd9, 1'b0, 4'd9, 1'b0, 1'b1);
        repeat (2) tick(); check();
        clr_err = 1'b1;
        push("ovf_set_wins", 4'd9, 1'b0, 4'd9, 1'b0, 1'b1);
        tick(); check();
        rd_bin = 4'd9;
        push("ovf_clear", 4'd9, 1'b0, 4'd0, 1'b0, 1'b0);
        tick(); clr_err = 1'b0; check();

        // Walk toward the wrap with the reader trailing.
        settle("b10", 4'hF, 4'd10, 4'd1, 1'b0, 1'b0);
        settle("b11", 4'hE, 4'd11, 4'd2, 1'b0, 1'b0);
        settle("b12", 4'hA, 4'd12, 4'd3, 1'b0, 1'b0);
        settle("b13", 4'hB, 4'd13, 4'd4, 1'b0, 1'b0);
        settle("b14", 4'h9, 4'd14, 4'd5, 1'b0, 1'b0);
        rd_bin = 4'd14;
        push("wrap_rd14", 4'd14, 1'b0, 4'd0, 1'b0, 1'b0);
        tick(); check();
        settle("wrap_b15", 4'h8, 4'd15, 4'd1, 1'b0, 1'b0);
        settle("wrap_b0", 4'h0, 4'd0, 4'd2, 1'b0, 1'b0);

        // Illegal two-bit jump 0 -> 3.
        gray_in = 4'h3;
        push("bad_e2", 4'd0, 1'b0, 4'd2, 1'b0, 1'b0);
        repeat (2) tick(); check();
        push("bad_e3", 4'd2, 1'b1, 4'd2, 1'b1, 1'b0);
        tick(); check();

        // Second illegal jump 3 -> 0 lands on the same edge as clr_err.
        gray_in = 4'h0;
        repeat (2) tick();
        clr_err = 1'b1;
        push("clr_set_wins", 4'd0, 1'b1, 4'd4, 1'b1, 1'b0);
        tick(); clr_err = 1'b0; check();
        clr_err = 1'b1;
        push("clr_only", 4'd0, 1'b0, 4'd2, 1'b0, 1'b0);
        tick(); clr_err = 1'b0; check();

        // Build level 5 legally, then reset mid-operation.
        rd_bin = 4'd0;
        settle("r1", 4'h1, 4'd1, 4'd1, 1'b0, 1'b0);
        settle("r2", 4'h3, 4'd2, 4'd2, 1'b0, 1'b0);
        settle("r3", 4'h2, 4'd3, 4'd3, 1'b0, 1'b0);
        settle("r4", 4'h6, 4'd4, 4'd4, 1'b0, 1'b0);
        settle("r5", 4'h7, 4'd5, 4'd5, 1'b0, 1'b0);
        rst = 1'b1; clr_err = 1'b1;
        push("mid_rst", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick(); rst = 1'b0; clr_err = 1'b0; check();
        // Held gray 7 re-enters against a zeroed previous sample: a 3-bit step.
        push("rerun_e2", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) tick(); check();
        push("rerun_e3", 4'd5, 1'b1, 4'd0, 1'b1, 1'b0);
        tick(); check();
        push("rerun_e4", 4'd5, 1'b0, 4'd5, 1'b1, 1'b0);
        tick(); check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
